// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared constants, FSM state type and index helpers for the
// round-robin 8:1 mux select arbiter.
//   NUM_REQ : number of requesters / mux data inputs
//   SEL_W   : width of the mux select bus
//   state_e : arbiter FSM states
package mux_arb_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned SEL_W   = 3;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        OWN
    } state_e;

    // Select index -> one-hot grant vector.
    function automatic logic [NUM_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

    // Next index modulo NUM_REQ; relies on SEL_W-bit wraparound.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        return idx + SEL_W'(1);
    endfunction

endpackage

// File: rtl/mux_8_1_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotating priority encoder.
// Finds the first set request scanning ptr, ptr+1, ... wrapping modulo NUM_REQ.
//   req : request vector
//   ptr : index with highest priority
//   win : winning index (equals ptr when nothing is requested)
//   any : at least one request is set
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   win,
    output logic               any
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [SEL_W-1:0]     off;

    always_comb begin
        // Rotate so that bit 0 of rot is requester ptr.
        dbl = {req, req} >> ptr;
        rot = dbl[NUM_REQ-1:0];
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = SEL_W'(k);
            end
        end
        any = |req;
        win = ptr + off;
    end

endmodule

// File: rtl/mux_8_1_rr_arbiter.sv
// mux_8_1_rr_arbiter: round-robin owner selection for a shared 8:1 data mux.
// Drives the mux select S, waits SETTLE_CYCLES for the mux path to settle,
// then asserts a registered one-hot GNT together with VALID.
// Optional feature macro: RR_SEL_LOCK_EN adds the LOCK input, which lets the
// current owner keep its grant past MAX_HOLD.
//   CLK   : clock, rising edge
//   RST   : synchronous active-high reset
//   REQ   : request vector, one bit per requester
//   LOCK  : owner extends grant past MAX_HOLD (RR_SEL_LOCK_EN only)
//   S     : mux select = index of current/last owner
//   GNT   : one-hot grant
//   VALID : mux output belongs to owner S this cycle
module mux_8_1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,  // 1..4
    parameter int unsigned MAX_HOLD      = 16  // 1..256
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] REQ,
`ifdef RR_SEL_LOCK_EN
    input  logic               LOCK,
`endif
    output logic [SEL_W-1:0]   S,
    output logic [NUM_REQ-1:0] GNT,
    output logic               VALID
);

    localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD - 1);
    // Settle countdown reaches zero in the last settle cycle. After a release
    // the release cycle itself precedes the settle window, hence one extra.
    localparam logic [2:0] SETTLE_LOAD     = 3'(SETTLE_CYCLES - 1);
    localparam logic [2:0] SETTLE_LOAD_REL = 3'(SETTLE_CYCLES);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   s_q, s_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               valid_q, valid_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         settle_q, settle_d;

    logic [SEL_W-1:0]   pick_ptr;
    logic [SEL_W-1:0]   pick_win;
    logic               pick_any;
    logic               lock_hold;
    logic               release_own;

`ifdef RR_SEL_LOCK_EN
    assign lock_hold = LOCK;
`else
    assign lock_hold = 1'b0;
`endif

    // In OWN the only pick that matters is the one made at release, which
    // must start from the pointer being written, i.e. owner + 1.
    assign pick_ptr = (state_q == OWN) ? next_idx(s_q) : ptr_q;

    rr_pick u_rr_pick (
        .req (REQ),
        .ptr (pick_ptr),
        .win (pick_win),
        .any (pick_any)
    );

    assign release_own = !REQ[s_q] || ((cnt_q == HOLD_LIMIT) && !lock_hold);

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        gnt_d    = gnt_q;
        valid_d  = valid_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    s_d      = pick_win;
                    settle_d = SETTLE_LOAD;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                // REQ is deliberately ignored here: the grant is always issued.
                if (settle_q == 3'd0) begin
                    gnt_d   = sel_to_onehot(s_q);
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = OWN;
                end else begin
                    settle_d = settle_q - 3'd1;
                end
            end
            OWN: begin
                if (release_own) begin
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = next_idx(s_q);
                    if (pick_any) begin
                        s_d      = pick_win;
                        settle_d = SETTLE_LOAD_REL;
                        state_d  = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q != HOLD_LIMIT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            s_q      <= '0;
            gnt_q    <= '0;
            valid_q  <= 1'b0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            gnt_q    <= gnt_d;
            valid_q  <= valid_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
        end
    end

    assign S     = s_q;
    assign GNT   = gnt_q;
    assign VALID = valid_q;

endmodule

// File: tb/tb_mux_8_1_rr_arbiter.sv
// Testbench for mux_8_1_rr_arbiter. Two instances share the stimulus:
//   A: SETTLE_CYCLES=1, MAX_HOLD=4     B: SETTLE_CYCLES=2, MAX_HOLD=16
// Both are compared every cycle against a behavioural model; A is also
// checked against a hand-derived vector table and closed-form sequences.
module tb_mux_8_1_rr_arbiter;

`ifdef RR_SEL_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       lock = 1'b0;

    logic [2:0] s_a, s_b;
    logic [7:0] gnt_a, gnt_b;
    logic       valid_a, valid_b;

    always #5 clk = ~clk;

    mux_8_1_rr_arbiter #(
        .SETTLE_CYCLES (1),
        .MAX_HOLD      (4)
    ) dut_a (
        .CLK   (clk),
        .RST   (rst),
        .REQ   (req),
`ifdef RR_SEL_LOCK_EN
        .LOCK  (lock),
`endif
        .S     (s_a),
        .GNT   (gnt_a),
        .VALID (valid_a)
    );

    mux_8_1_rr_arbiter #(
        .SETTLE_CYCLES (2),
        .MAX_HOLD      (16)
    ) dut_b (
        .CLK   (clk),
        .RST   (rst),
        .REQ   (req),
`ifdef RR_SEL_LOCK_EN
        .LOCK  (lock),
`endif
        .S     (s_b),
        .GNT   (gnt_b),
        .VALID (valid_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: phase 0 = no owner, 1 = waiting (non-VALID cycles
    // before the grant), 2 = owning. held counts VALID cycles of this grant.
    int m_s[2], m_gnt[2], m_valid[2], m_ptr[2], m_phase[2], m_wait[2], m_held[2];
    int run_len[2];

    function automatic int rr_winner(input int rq, input int ptr);
        for (int k = 0; k < 8; k++) begin
            if (rq[(ptr + k) % 8]) return (ptr + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_step(input int i, input bit r, input int rq, input bit lk);
        int sc, mh, w;
        sc = (i == 0) ? 1 : 2;
        mh = (i == 0) ? 4 : 16;
        if (r) begin
            m_s[i] = 0; m_gnt[i] = 0; m_valid[i] = 0; m_ptr[i] = 0;
            m_phase[i] = 0; m_wait[i] = 0; m_held[i] = 0;
        end else if (m_phase[i] == 0) begin
            w = rr_winner(rq, m_ptr[i]);
            if (w >= 0) begin
                m_s[i] = w; m_wait[i] = sc; m_phase[i] = 1;
            end
        end else if (m_phase[i] == 1) begin
            if (m_wait[i] == 1) begin
                m_gnt[i] = 1 << m_s[i]; m_valid[i] = 1; m_held[i] = 1; m_phase[i] = 2;
            end else begin
                m_wait[i]--;
            end
        end else begin
            if (!rq[m_s[i]] || (m_held[i] >= mh && !(LOCK_EN && lk))) begin
                m_gnt[i] = 0; m_valid[i] = 0;
                m_ptr[i] = (m_s[i] + 1) % 8;
                w = rr_winner(rq, m_ptr[i]);
                if (w >= 0) begin
                    m_s[i] = w; m_wait[i] = sc + 1; m_phase[i] = 1;
                end else begin
                    m_phase[i] = 0;
                end
            end else begin
                m_held[i]++;
            end
        end
    endtask

    task automatic compare_all();
        check("A.S", 32'(s_a), 32'(m_s[0]));
        check("A.GNT", 32'(gnt_a), 32'(m_gnt[0]));
        check("A.VALID", 32'(valid_a), 32'(m_valid[0]));
        check("B.S", 32'(s_b), 32'(m_s[1]));
        check("B.GNT", 32'(gnt_b), 32'(m_gnt[1]));
        check("B.VALID", 32'(valid_b), 32'(m_valid[1]));
    endtask

    // Drive inputs, clock one edge, advance the model, compare at negedge.
    task automatic cyc(input bit r, input logic [7:0] rq, input bit lk);
        rst  = r;
        req  = rq;
        lock = lk;
        @(posedge clk);
        model_step(0, r, int'(rq), lk);
        model_step(1, r, int'(rq), lk);
        @(negedge clk);
        compare_all();
    endtask

    // Length of each completed VALID run must equal want.
    task automatic track(input int i, input logic v, input int want);
        if (v) begin
            run_len[i]++;
        end else if (run_len[i] > 0) begin
            check((i == 0) ? "A.run_len" : "B.run_len", 32'(run_len[i]), 32'(want));
            run_len[i] = 0;
        end
    endtask

    typedef struct {
        bit         rst;
        logic [7:0] req;
        logic [2:0] s;
        logic [7:0] gnt;
        bit         valid;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [7:0] rq;
        bit         r;
        int         exp_owner;
        bit         exp_v;

        // Expected values for instance A after each edge.
        tbl[0]  = '{1'b1, 8'h00, 3'd0, 8'h00, 1'b0};  // reset
        tbl[1]  = '{1'b0, 8'h04, 3'd2, 8'h00, 1'b0};  // S set, settling
        tbl[2]  = '{1'b0, 8'h04, 3'd2, 8'h04, 1'b1};  // grant
        tbl[3]  = '{1'b0, 8'h04, 3'd2, 8'h04, 1'b1};
        tbl[4]  = '{1'b0, 8'h00, 3'd2, 8'h00, 1'b0};  // drop -> release, PTR=3
        tbl[5]  = '{1'b0, 8'h05, 3'd0, 8'h00, 1'b0};  // wrap from 3 -> 0
        tbl[6]  = '{1'b0, 8'h05, 3'd0, 8'h01, 1'b1};
        tbl[7]  = '{1'b0, 8'h00, 3'd0, 8'h00, 1'b0};  // PTR=1
        tbl[8]  = '{1'b0, 8'h10, 3'd4, 8'h00, 1'b0};
        tbl[9]  = '{1'b0, 8'h10, 3'd4, 8'h10, 1'b1};
        tbl[10] = '{1'b1, 8'h10, 3'd0, 8'h00, 1'b0};  // reset inside OWN
        tbl[11] = '{1'b0, 8'h81, 3'd0, 8'h00, 1'b0};  // PTR back to 0 -> 0, not 7
        tbl[12] = '{1'b0, 8'h81, 3'd0, 8'h01, 1'b1};
        tbl[13] = '{1'b0, 8'h00, 3'd0, 8'h00, 1'b0};

        for (int i = 0; i < 2; i++) begin
            model_step(i, 1'b1, 0, 1'b0);
            run_len[i] = 0;
        end
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].rst, tbl[i].req, 1'b0);
            check($sformatf("tbl%0d.S", i), 32'(s_a), 32'(tbl[i].s));
            check($sformatf("tbl%0d.GNT", i), 32'(gnt_a), 32'(tbl[i].gnt));
            check($sformatf("tbl%0d.VALID", i), 32'(valid_a), 32'(tbl[i].valid));
        end

        // All requesting: A owners 0,1,..,7,0 with 4 VALID then 2 idle cycles.
        cyc(1'b1, 8'h00, 1'b0);
        run_len[0] = 0;
        for (int c = 1; c <= 56; c++) begin
            cyc(1'b0, 8'hFF, 1'b0);
            exp_v     = (c >= 2) && (((c - 2) % 6) < 4);
            exp_owner = (c >= 2) ? (((c - 2) / 6) % 8) : 0;
            check($sformatf("ff%0d.VALID", c), 32'(valid_a), 32'(exp_v));
            check($sformatf("ff%0d.GNT", c), 32'(gnt_a), exp_v ? (32'd1 << exp_owner) : 32'd0);
            track(0, valid_a, 4);
        end

        // Single requester 5 held 40 cycles: B regrants in 16-cycle runs.
        cyc(1'b1, 8'h00, 1'b0);
        run_len[0] = 0;
        run_len[1] = 0;
        for (int c = 1; c <= 40; c++) begin
            cyc(1'b0, 8'h20, 1'b0);
            if (valid_b) check("B.gnt5", 32'(gnt_b), 32'h20);
            track(0, valid_a, 4);
            track(1, valid_b, 16);
        end

`ifdef RR_SEL_LOCK_EN
        // LOCK held: A keeps requester 1 for 10 VALID cycles despite MAX_HOLD=4.
        cyc(1'b1, 8'h00, 1'b0);
        run_len[0] = 0;
        for (int c = 1; c <= 12; c++) begin
            cyc(1'b0, (c <= 11) ? 8'h02 : 8'h00, 1'b1);
            track(0, valid_a, 10);
        end
        // LOCK dropped at cycle 6 with the counter at its limit: release after edge 6.
        cyc(1'b1, 8'h00, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            cyc(1'b0, 8'h02, (c <= 5));
            if (c == 5) check("lock.held5", 32'(valid_a), 32'd1);
            if (c == 6) check("lock.rel6", 32'(valid_a), 32'd0);
        end
`endif

        // Randomized traffic against the model.
        cyc(1'b1, 8'h00, 1'b0);
        rq = 8'h00;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) rq = 8'($urandom() & $urandom());
            r = ($urandom_range(0, 63) == 0);
            cyc(r, rq, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
